// File: rtl/posit_regime_unpack_if.sv
// ============================================================================
// Module  : posit_regime_unpack_if
// Purpose : Input/output stream bundle for the posit field extractor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface posit_regime_unpack_if #(
    parameter int N  = 16,
    parameter int ES = 1
);
    localparam int KW = $clog2(N) + 1;
    localparam int RW = $clog2(N);
    localparam int FW = N - 3 - ES;
    localparam int EW = (ES > 0) ? ES : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_posit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic                 out_zero;
    logic                 out_nar;
    logic signed [KW-1:0] out_k;
    logic [RW-1:0]        out_reg_len;
    logic [EW-1:0]        out_exp;
    logic [FW-1:0]        out_frac;

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_zero, out_nar,
               out_k, out_reg_len, out_exp, out_frac
    );

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_zero, out_nar,
               out_k, out_reg_len, out_exp, out_frac
    );
endinterface

`default_nettype wire

// File: rtl/posit_regime_unpack.sv
// ============================================================================
// Module  : posit_regime_unpack
// Purpose : Two-stage valid/ready posit field extractor (sign, flags, regime
//           k, regime length, exponent, left-aligned fraction).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module posit_regime_unpack #(
    parameter int N  = 16,
    parameter int ES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    posit_regime_unpack_if.slave  bus
);
    localparam int c_BW = N - 1;
    localparam int c_KW = $clog2(N) + 1;
    localparam int c_RW = $clog2(N);
    localparam int c_FW = N - 3 - ES;
    localparam int c_EW = (ES > 0) ? ES : 1;
    // Bits left after the shortest (2-bit) regime: exponent plus fraction.
    localparam int c_TW = N - 3;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_load;
    logic w_s1_load;

    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: flags and magnitude body
    // ------------------------------------------------------------------
    logic              r_s1_sign;
    logic              r_s1_zero;
    logic              r_s1_nar;
    logic [c_BW-1:0]   r_s1_body;

    logic              w_zero_in;
    logic              w_nar_in;
    logic [c_BW-1:0]   w_body_in;

    assign w_zero_in = (bus.in_posit == '0);
    assign w_nar_in  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});
    // Low bits of a two's complement depend only on the low bits of the input.
    assign w_body_in = bus.in_posit[N-1]
                     ? (~bus.in_posit[c_BW-1:0] + {{(c_BW-1){1'b0}}, 1'b1})
                     : bus.in_posit[c_BW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_body  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign <= bus.in_posit[N-1];
                r_s1_zero <= w_zero_in;
                r_s1_nar  <= w_nar_in;
                r_s1_body <= w_body_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode: regime run, k, field alignment
    // ------------------------------------------------------------------
    logic                    w_r0;
    logic [c_BW-1:0]         w_run;
    logic [c_RW-1:0]         w_m;
    logic [c_RW-1:0]         w_reg_len;
    logic [c_RW-1:0]         w_shamt;
    logic [c_KW-1:0]         w_m_ext;
    logic signed [c_KW-1:0]  w_k;
    logic [c_TW-1:0]         w_fields;
    logic [c_EW-1:0]         w_exp;
    logic [c_FW-1:0]         w_frac;
    logic                    w_special;

    // Inverting when r0=1 turns the run into a leading-zero count.
    assign w_r0  = r_s1_body[c_BW-1];
    assign w_run = w_r0 ? ~r_s1_body : r_s1_body;

    always_comb begin : p_run_length
        logic found;
        found = 1'b0;
        w_m   = c_RW'(c_BW);
        for (int i = c_BW - 1; i >= 0; i--) begin
            if (!found && w_run[i]) begin
                w_m   = c_RW'(c_BW - 1 - i);
                found = 1'b1;
            end
        end
    end

    assign w_reg_len = (w_m == c_RW'(c_BW)) ? w_m : (w_m + c_RW'(1));
    assign w_m_ext   = {1'b0, w_m};
    assign w_k       = w_r0 ? $signed(w_m_ext - c_KW'(1))
                            : $signed(c_KW'(0) - w_m_ext);

    // Regime is at least 2 bits, so the fields start within the low c_TW
    // body bits; a full-length regime shifts everything out to zero.
    assign w_shamt  = w_reg_len - c_RW'(2);
    assign w_fields = r_s1_body[c_TW-1:0] << w_shamt;
    assign w_frac   = w_fields[c_FW-1:0];

    generate
        if (ES > 0) begin : g_exp_field
            assign w_exp = w_fields[c_TW-1 -: c_EW];
        end else begin : g_exp_none
            assign w_exp = '0;
        end
    endgenerate

    assign w_special = r_s1_zero || r_s1_nar;

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic                    r_out_sign;
    logic                    r_out_zero;
    logic                    r_out_nar;
    logic signed [c_KW-1:0]  r_out_k;
    logic [c_RW-1:0]         r_out_reg_len;
    logic [c_EW-1:0]         r_out_exp;
    logic [c_FW-1:0]         r_out_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_out_sign    <= 1'b0;
            r_out_zero    <= 1'b0;
            r_out_nar     <= 1'b0;
            r_out_k       <= '0;
            r_out_reg_len <= '0;
            r_out_exp     <= '0;
            r_out_frac    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_zero    <= r_s1_zero;
                r_out_nar     <= r_s1_nar;
                r_out_sign    <= w_special ? 1'b0 : r_s1_sign;
                r_out_k       <= w_special ? '0   : w_k;
                r_out_reg_len <= w_special ? '0   : w_reg_len;
                r_out_exp     <= w_special ? '0   : w_exp;
                r_out_frac    <= w_special ? '0   : w_frac;
            end
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.out_sign    = r_out_sign;
    assign bus.out_zero    = r_out_zero;
    assign bus.out_nar     = r_out_nar;
    assign bus.out_k       = r_out_k;
    assign bus.out_reg_len = r_out_reg_len;
    assign bus.out_exp     = r_out_exp;
    assign bus.out_frac    = r_out_frac;

endmodule

`default_nettype wire

// File: tb/tb_posit_regime_unpack.sv
// ============================================================================
// Module  : tb_posit_regime_unpack
// Purpose : Directed bench for posit_regime_unpack at N=16/ES=1, N=8/ES=0
//           and N=32/ES=2.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_posit_regime_unpack;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    posit_regime_unpack_if #(.N(16), .ES(1)) bus16 ();
    posit_regime_unpack_if #(.N(8),  .ES(0)) bus8  ();
    posit_regime_unpack_if #(.N(32), .ES(2)) bus32 ();

    posit_regime_unpack #(.N(16), .ES(1)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    posit_regime_unpack #(.N(8),  .ES(0)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    posit_regime_unpack #(.N(32), .ES(2)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packing: {valid, sign, zero, nar, k, reg_len, exp, frac}
    function automatic logic [25:0] obs16();
        return {bus16.out_valid, bus16.out_sign, bus16.out_zero, bus16.out_nar,
                bus16.out_k, bus16.out_reg_len, bus16.out_exp, bus16.out_frac};
    endfunction
    function automatic logic [16:0] obs8();
        return {bus8.out_valid, bus8.out_sign, bus8.out_zero, bus8.out_nar,
                bus8.out_k, bus8.out_reg_len, bus8.out_exp, bus8.out_frac};
    endfunction
    function automatic logic [43:0] obs32();
        return {bus32.out_valid, bus32.out_sign, bus32.out_zero, bus32.out_nar,
                bus32.out_k, bus32.out_reg_len, bus32.out_exp, bus32.out_frac};
    endfunction

    function automatic logic [25:0] e16(input logic s, z, n, input int k, rl,
                                        input logic e, input logic [11:0] f);
        return {1'b1, s, z, n, 5'(k), 4'(rl), e, f};
    endfunction
    function automatic logic [16:0] e8(input logic s, z, n, input int k, rl,
                                       input logic [4:0] f);
        return {1'b1, s, z, n, 4'(k), 3'(rl), 1'b0, f};
    endfunction
    function automatic logic [43:0] e32(input logic s, z, n, input int k, rl,
                                        input logic [1:0] e, input logic [26:0] f);
        return {1'b1, s, z, n, 6'(k), 5'(rl), e, f};
    endfunction

    // Bit-walking reference decoder for N=16, ES=1.
    function automatic logic [25:0] model16(input logic [15:0] w);
        logic [15:0] v;
        logic        r0;
        logic        e;
        logic [11:0] f;
        int          m, idx, k, rl, pos;
        if (w == 16'h0000) return e16(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 12'h0);
        if (w == 16'h8000) return e16(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 12'h0);
        v   = w[15] ? (~w + 16'd1) : w;
        r0  = v[14];
        m   = 0;
        idx = 14;
        while (idx >= 0 && v[idx] == r0) begin
            m++;
            idx--;
        end
        k   = r0 ? (m - 1) : -m;
        rl  = (m + 1 > 15) ? 15 : (m + 1);
        pos = 14 - rl;
        e   = (pos >= 0) ? v[pos] : 1'b0;
        pos--;
        for (int j = 11; j >= 0; j--) begin
            f[j] = (pos >= 0) ? v[pos] : 1'b0;
            pos--;
        end
        return e16(w[15], 1'b0, 1'b0, k, rl, e, f);
    endfunction

    task automatic apply16(input logic [15:0] w);
        bus16.in_valid = 1'b1;
        bus16.in_posit = w;
        tick();
        bus16.in_valid = 1'b0;
        chk("lat16_early", 64'(bus16.out_valid), 64'(0));
        tick();
    endtask

    task automatic apply8(input logic [7:0] w);
        bus8.in_valid = 1'b1;
        bus8.in_posit = w;
        tick();
        bus8.in_valid = 1'b0;
        tick();
    endtask

    task automatic apply32(input logic [31:0] w);
        bus32.in_valid = 1'b1;
        bus32.in_posit = w;
        tick();
        bus32.in_valid = 1'b0;
        tick();
    endtask

    logic [15:0] words [20];

    initial begin
        rst_n           = 1'b0;
        bus16.in_valid  = 1'b0; bus16.in_posit = '0; bus16.out_ready = 1'b1;
        bus8.in_valid   = 1'b0; bus8.in_posit  = '0; bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0; bus32.in_posit = '0; bus32.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out16", 64'(obs16()), 64'(0));
        chk("rst_rdy16", 64'(bus16.in_ready), 64'(1));
        chk("rst_out8",  64'(obs8()),  64'(0));
        chk("rst_out32", 64'(obs32()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // N=16, ES=1 directed
        apply16(16'h0000); chk("zero16",  64'(obs16()), 64'(e16(0, 1, 0,   0,  0, 0, 12'h000)));
        apply16(16'h8000); chk("nar16",   64'(obs16()), 64'(e16(0, 0, 1,   0,  0, 0, 12'h000)));
        apply16(16'h4000); chk("one16",   64'(obs16()), 64'(e16(0, 0, 0,   0,  2, 0, 12'h000)));
        apply16(16'hC000); chk("mone16",  64'(obs16()), 64'(e16(1, 0, 0,   0,  2, 0, 12'h000)));
        apply16(16'h5000); chk("exp16",   64'(obs16()), 64'(e16(0, 0, 0,   0,  2, 1, 12'h000)));
        apply16(16'h7FFF); chk("maxk16",  64'(obs16()), 64'(e16(0, 0, 0,  14, 15, 0, 12'h000)));
        apply16(16'h0001); chk("mink16",  64'(obs16()), 64'(e16(0, 0, 0, -14, 15, 0, 12'h000)));
        apply16(16'h0002); chk("nmin16",  64'(obs16()), 64'(e16(0, 0, 0, -13, 14, 0, 12'h000)));
        apply16(16'h3A5C); chk("frac16",  64'(obs16()), 64'(e16(0, 0, 0,  -1,  2, 1, 12'hA5C)));
        apply16(16'hC5A4); chk("nfrac16", 64'(obs16()), 64'(e16(1, 0, 0,  -1,  2, 1, 12'hA5C)));
        apply16(16'h7A00); chk("k3_16",   64'(obs16()), 64'(e16(0, 0, 0,   3,  5, 1, 12'h000)));

        // Streaming: one result per cycle, two edges after presentation
        for (int i = 0; i < 20; i++) words[i] = 16'($urandom);
        for (int i = 0; i <= 20; i++) begin
            bus16.in_valid = (i < 20);
            bus16.in_posit = (i < 20) ? words[i] : 16'h0000;
            tick();
            if (i >= 1) chk($sformatf("stream%0d", i - 1), 64'(obs16()), 64'(model16(words[i-1])));
        end
        bus16.in_valid = 1'b0;
        tick();
        chk("stream_drain", 64'(bus16.out_valid), 64'(0));

        // Backpressure: three words, consumer stalled for four edges
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.in_posit  = 16'h3A5C;
        tick();
        bus16.in_posit  = 16'h7A00;
        tick();
        bus16.in_posit  = 16'h0002;
        chk("bp_rdy_low",  64'(bus16.in_ready), 64'(0));
        chk("bp_hold_a",   64'(obs16()), 64'(model16(16'h3A5C)));
        tick();
        chk("bp_hold_b",   64'(obs16()), 64'(model16(16'h3A5C)));
        tick();
        chk("bp_hold_c",   64'(obs16()), 64'(model16(16'h3A5C)));
        chk("bp_rdy_low2", 64'(bus16.in_ready), 64'(0));
        bus16.out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", 64'(bus16.in_ready), 64'(1));
        tick();
        bus16.in_valid  = 1'b0;
        chk("bp_out1",     64'(obs16()), 64'(model16(16'h7A00)));
        tick();
        chk("bp_out2",     64'(obs16()), 64'(model16(16'h0002)));
        tick();
        chk("bp_empty",    64'(bus16.out_valid), 64'(0));

        // Asynchronous reset with two words in flight
        bus16.out_ready = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.in_posit  = 16'h4000;
        tick();
        bus16.in_posit  = 16'h5000;
        tick();
        bus16.in_valid  = 1'b0;
        chk("rst_pre_full", 64'(bus16.out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 64'(obs16()), 64'(0));
        chk("rst_mid_rdy", 64'(bus16.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        tick(); chk("rst_stale0", 64'(bus16.out_valid), 64'(0));
        tick(); chk("rst_stale1", 64'(bus16.out_valid), 64'(0));
        apply16(16'h3A5C); chk("post_rst16", 64'(obs16()), 64'(e16(0, 0, 0, -1, 2, 1, 12'hA5C)));

        // N=8, ES=0
        apply8(8'h00); chk("zero8",  64'(obs8()), 64'(e8(0, 1, 0,  0, 0, 5'h00)));
        apply8(8'h80); chk("nar8",   64'(obs8()), 64'(e8(0, 0, 1,  0, 0, 5'h00)));
        apply8(8'h40); chk("one8",   64'(obs8()), 64'(e8(0, 0, 0,  0, 2, 5'h00)));
        apply8(8'h7F); chk("maxk8",  64'(obs8()), 64'(e8(0, 0, 0,  6, 7, 5'h00)));
        apply8(8'h01); chk("mink8",  64'(obs8()), 64'(e8(0, 0, 0, -6, 7, 5'h00)));
        apply8(8'h5B); chk("frac8",  64'(obs8()), 64'(e8(0, 0, 0,  0, 2, 5'h1B)));
        apply8(8'hA5); chk("nfrac8", 64'(obs8()), 64'(e8(1, 0, 0,  0, 2, 5'h1B)));

        // N=32, ES=2
        apply32(32'h4000_0000); chk("one32",  64'(obs32()), 64'(e32(0, 0, 0,   0,  2, 2'd0, 27'h0)));
        apply32(32'h6C00_0001); chk("mix32",  64'(obs32()), 64'(e32(0, 0, 0,   1,  3, 2'd3, 27'h2)));
        apply32(32'h0000_0001); chk("mink32", 64'(obs32()), 64'(e32(0, 0, 0, -30, 31, 2'd0, 27'h0)));
        apply32(32'h7FFF_FFFF); chk("maxk32", 64'(obs32()), 64'(e32(0, 0, 0,  30, 31, 2'd0, 27'h0)));
        apply32(32'h8000_0000); chk("nar32",  64'(obs32()), 64'(e32(0, 0, 1,   0,  0, 2'd0, 27'h0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire
